cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cache.sv | 165 ++++++++++++++++
 tb/tb_cache.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped 16 KB write-back cache: 1024 lines of 4 words, 32-bit byte addresses.
// Define CACHE_WRITE_ALLOCATE_EN to allocate on write miss; otherwise write misses go around.
module cache (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_nwait,
    output logic        dram_cs,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_din,
    input  logic [31:0] dram_dout,
    input  logic        dram_nwait
);

    typedef enum logic [2:0] {
        IDLE, WB_ISSUE, WB_WAIT, RF_ISSUE, RF_WAIT, RESPOND
    } state_e;

`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam bit WrAlloc = 1'b1;
`else
    localparam bit WrAlloc = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [1023:0] valid_q, dirty_q;
    logic [17:0]   tag_q  [1024];
    logic [31:0]   data_q [4096];
    logic [31:0]   req_addr_q, req_din_q;
    logic          req_we_q;

    logic [9:0]    cidx, ridx;
    logic [11:0]   cword, rword;
    logic          hit, miss, vdirty, around, thru, last_rf;
    logic          unused_ok;

    assign cidx    = cpu_addr[13:4];
    assign ridx    = req_addr_q[13:4];
    assign cword   = cpu_addr[13:2];
    assign rword   = req_addr_q[13:2];
    assign hit     = valid_q[cidx] && (tag_q[cidx] == cpu_addr[31:14]);
    assign miss    = cpu_cs && !hit;
    assign vdirty  = valid_q[cidx] && dirty_q[cidx];
    assign around  = !WrAlloc && cpu_we;
    // thru marks a write-around miss: a single DRAM write, no line traffic
    assign thru    = !WrAlloc && req_we_q;
    assign last_rf = (state_q == RF_WAIT) && dram_nwait && (k_q == 2'd3);
    assign unused_ok = ^{cpu_addr[1:0], req_addr_q[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (miss) state_d = (around || vdirty) ? WB_ISSUE : RF_ISSUE;
            end
            WB_ISSUE: state_d = WB_WAIT;
            WB_WAIT: begin
                if (dram_nwait) begin
                    if (thru) begin
                        state_d = RESPOND;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = (k_q == 2'd3) ? RF_ISSUE : WB_ISSUE;
                    end
                end
            end
            RF_ISSUE: state_d = RF_WAIT;
            RF_WAIT: begin
                if (dram_nwait) begin
                    k_d     = k_q + 2'd1;
                    state_d = (k_q == 2'd3) ? RESPOND : RF_ISSUE;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_nwait = 1'b0;
        cpu_dout  = '0;
        dram_cs   = 1'b0;
        dram_we   = 1'b0;
        dram_addr = '0;
        dram_din  = '0;
        unique case (state_q)
            IDLE: begin
                cpu_nwait = !miss;
                if (cpu_cs && hit && !cpu_we) cpu_dout = data_q[cword];
            end
            WB_ISSUE, WB_WAIT: begin
                dram_cs = (state_q == WB_ISSUE);
                dram_we = 1'b1;
                if (thru) begin
                    dram_addr = {req_addr_q[31:2], 2'b00};
                    dram_din  = req_din_q;
                end else begin
                    dram_addr = {tag_q[ridx], ridx, k_q, 2'b00};
                    dram_din  = data_q[{ridx, k_q}];
                end
            end
            RF_ISSUE, RF_WAIT: begin
                dram_cs   = (state_q == RF_ISSUE);
                dram_addr = {req_addr_q[31:4], k_q, 2'b00};
            end
            RESPOND: begin
                cpu_nwait = 1'b1;
                if (!req_we_q) cpu_dout = data_q[rword];
            end
            default: cpu_nwait = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            req_addr_q <= '0;
            req_din_q  <= '0;
            req_we_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && cpu_cs) begin
                if (hit) begin
                    if (cpu_we) dirty_q[cidx] <= 1'b1;
                end else begin
                    req_addr_q <= cpu_addr;
                    req_din_q  <= cpu_din;
                    req_we_q   <= cpu_we;
                end
            end
            // line stays invalid until its last word has landed
            if (state_q == RF_ISSUE) valid_q[ridx] <= 1'b0;
            if (last_rf) begin
                valid_q[ridx] <= 1'b1;
                dirty_q[ridx] <= 1'b0;
            end
            if (state_q == RESPOND && req_we_q && !thru) dirty_q[ridx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && cpu_cs && hit && cpu_we) data_q[cword] <= cpu_din;
        if (state_q == RF_WAIT && dram_nwait) data_q[{ridx, k_q}] <= dram_dout;
        if (last_rf) tag_q[ridx] <= req_addr_q[31:14];
        if (state_q == RESPOND && req_we_q && !thru) data_q[rword] <= req_din_q;
    end

endmodule

// File: tb/tb_cache.sv
// Bench for cache: transaction-level cache model, 4-cycle DRAM model, scoreboard monitor.
`timescale 1ns/1ps
module tb_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        cpu_nwait;
    logic        dram_cs, dram_we;
    logic [31:0] dram_addr, dram_din;
    logic [31:0] dram_dout = '0;
    logic        dram_nwait = 1'b1;

    always #5 clk = ~clk;

    cache dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_nwait(cpu_nwait),
        .dram_cs(dram_cs), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_din(dram_din), .dram_dout(dram_dout), .dram_nwait(dram_nwait)
    );

    typedef struct { logic we; logic [31:0] dout; int lat; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } dop_t;

    rsp_t        sb[$];
    dop_t        dq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat = 0;
    int          dcnt = 0;
    logic [31:0] seed;
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] gmem [logic [31:0]];
    bit          rv [1024];
    bit          rd [1024];
    logic [17:0] rt [1024];
    logic [31:0] rdat [1024][4];
    logic        cap_cs = 1'b0, cap_we = 1'b0;
    logic [31:0] cap_addr = '0, cap_din = '0;

    function automatic logic [31:0] initv(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ seed;
    endfunction

    function automatic logic [31:0] gread(input logic [31:0] a);
        return gmem.exists(a) ? gmem[a] : initv(a);
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // DRAM: strobe sampled on an edge, nwait low for the next 3 cycles
    always @(negedge clk) begin
        cap_cs   = dram_cs;
        cap_we   = dram_we;
        cap_addr = dram_addr;
        cap_din  = dram_din;
        if (rst_n && dram_cs) begin
            chk(dq.size() != 0, "dram_unexpected", dram_addr, 32'h0);
            if (dq.size() != 0) begin
                dop_t e;
                e = dq.pop_front();
                chk(dram_we == e.we, "dram_we", {31'b0, dram_we}, {31'b0, e.we});
                chk(dram_addr == e.addr, "dram_addr", dram_addr, e.addr);
                if (e.we) chk(dram_din == e.data, "dram_din", dram_din, e.data);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt       <= 0;
            dram_nwait <= 1'b1;
            dram_dout  <= '0;
        end else if (cap_cs) begin
            if (cap_we) dmem[cap_addr] = cap_din;
            else dram_dout <= dmem.exists(cap_addr) ? dmem[cap_addr] : initv(cap_addr);
            dram_nwait <= 1'b0;
            dcnt       <= 3;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) dram_nwait <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            lat = 0;
        end else if (cpu_cs) begin
            if (!cpu_nwait) begin
                lat++;
            end else begin
                chk(sb.size() != 0, "sb_empty", cpu_addr, 32'h0);
                if (sb.size() != 0) begin
                    rsp_t e;
                    e = sb.pop_front();
                    chk(lat == e.lat, "latency", lat, e.lat);
                    chk(cpu_dout == e.dout, "cpu_dout", cpu_dout, e.dout);
                end
                lat = 0;
            end
        end
    end

    task automatic predict(input logic we, input logic [31:0] a, input logic [31:0] d);
        rsp_t        r;
        logic [9:0]  idx;
        logic [17:0] tg;
        logic [1:0]  w;
        logic [31:0] va;
        bit          around;
        idx = a[13:4];
        tg  = a[31:14];
        w   = a[3:2];
        r.we = we;
        r.dout = '0;
        r.lat = 0;
`ifdef CACHE_WRITE_ALLOCATE_EN
        around = 1'b0;
`else
        around = we;
`endif
        if (!(rv[idx] && rt[idx] == tg)) begin
            if (around) begin
                r.lat = 6;
                va = {a[31:2], 2'b00};
                dq.push_back('{1'b1, va, d});
                gmem[va] = d;
            end else begin
                r.lat = 21;
                if (rv[idx] && rd[idx]) begin
                    r.lat = 41;
                    for (int k = 0; k < 4; k++) begin
                        va = {rt[idx], idx, 2'(k), 2'b00};
                        dq.push_back('{1'b1, va, rdat[idx][k]});
                        gmem[va] = rdat[idx][k];
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    va = {a[31:4], 2'(k), 2'b00};
                    dq.push_back('{1'b0, va, 32'h0});
                    rdat[idx][k] = gread(va);
                end
                rv[idx] = 1'b1;
                rd[idx] = 1'b0;
                rt[idx] = tg;
            end
        end
        if (!(around && r.lat != 0)) begin
            if (we) begin
                rdat[idx][w] = d;
                rd[idx] = 1'b1;
            end else begin
                r.dout = rdat[idx][w];
            end
        end
        sb.push_back(r);
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit got;
        predict(we, a, d);
        cpu_we = we;
        cpu_addr = a;
        cpu_din = d;
        cpu_cs = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = cpu_nwait;
        end
        if (!got) chk(1'b0, "timeout", a, 32'h0);
        @(posedge clk);
        #1;
        cpu_cs = 1'b0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 1024; i++) begin
            rv[i] = 1'b0;
            rd[i] = 1'b0;
        end
        sb.delete();
        dq.delete();
    endtask

    logic [31:0] tags [4];
    logic [9:0]  idxs [4];

    initial begin
        seed = $urandom;
        tags = '{32'h0000028D, 32'h0000028E, 32'h00000000, 32'h0003FFFF};
        idxs = '{10'h3B9, 10'h001, 10'h3FF, 10'h200};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(cpu_nwait == 1'b1, "rst_nwait", {31'b0, cpu_nwait}, 32'h1);
        chk(dram_cs == 1'b0, "rst_dram_cs", {31'b0, dram_cs}, 32'h0);
        chk(dram_we == 1'b0, "rst_dram_we", {31'b0, dram_we}, 32'h0);
        chk(dram_addr == 32'h0, "rst_dram_addr", dram_addr, 32'h0);
        chk(dram_din == 32'h0, "rst_dram_din", dram_din, 32'h0);
        chk(cpu_dout == 32'h0, "rst_cpu_dout", cpu_dout, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        req(1'b0, 32'h00A37B9C, 32'h0);
        req(1'b0, 32'h00A37B9C, 32'h0);
        req(1'b0, 32'h00A3BB98, 32'h0);
        req(1'b1, 32'h00A3BB90, 32'hFFFFFFFF);
        req(1'b0, 32'h00A37B94, 32'h0);
        chk(dmem.exists(32'h00A3BB90) && dmem[32'h00A3BB90] == 32'hFFFFFFFF,
            "wb_dram_word", dmem.exists(32'h00A3BB90) ? dmem[32'h00A3BB90] : 32'h0,
            32'hFFFFFFFF);
        req(1'b1, 32'h00ABCDE4, 32'h13572468);
        req(1'b0, 32'h00ABCDE4, 32'h0);

        // abandon a refill with reset, then the line must miss again
        predict(1'b0, 32'h00123458, 32'h0);
        cpu_we = 1'b0;
        cpu_addr = 32'h00123458;
        cpu_cs = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        cpu_cs = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk(cpu_nwait == 1'b1, "midrst_nwait", {31'b0, cpu_nwait}, 32'h1);
        chk(dram_cs == 1'b0, "midrst_dram_cs", {31'b0, dram_cs}, 32'h0);
        chk(dram_addr == 32'h0, "midrst_dram_addr", dram_addr, 32'h0);
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(1'b0, 32'h00123458, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [1:0]  ti, ii, wi;
            ti = 2'($urandom_range(0, 3));
            ii = 2'($urandom_range(0, 3));
            wi = 2'($urandom_range(0, 3));
            a = {tags[ti][17:0], idxs[ii], wi, 2'b00};
            req($urandom_range(0, 9) < 4, a, $urandom);
        end

        repeat (5) @(posedge clk);
        chk(sb.size() == 0, "sb_drained", sb.size(), 32'h0);
        chk(dq.size() == 0, "dram_drained", dq.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
